// File: rtl/parallel_multiplier_pkg.sv
// Shared constants for the parallel multiplier slice.
// Holds the default operand width used by the top level.
package parallel_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/parallel_multiplier_full_adder.sv
// One-bit full adder cell used in the multiplier's adder grid.
// A half adder is this cell with cin tied low.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/parallel_multiplier.sv
// Unsigned array multiplier: AND-gate partial products summed by ripple rows
// of full adders, with the full-precision product captured in an output register.
//
// Handshake: in_valid qualifies A/B. out_valid follows one cycle later and
// qualifies Y. There is no ready/backpressure; a new pair may arrive every cycle.
module parallel_multiplier
    import parallel_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   Y,
    output logic                 out_valid
);

    logic [WIDTH-1:0]   pp [WIDTH];
    logic [2*WIDTH-1:0] product;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = A & {WIDTH{B[i]}};
        end
    end

    assign product[0] = pp[0][0];

    genvar i, j;
    for (i = 1; i < WIDTH; i++) begin : g_row
        // addend is the previous row's sum shifted right by one, with its carry on top
        logic [WIDTH-1:0] addend;
        logic [WIDTH-1:0] sum;
        logic             cout_row;

        if (i == 1) begin : g_first
            assign addend = {1'b0, pp[0][WIDTH-1:1]};
        end else begin : g_next
            assign addend = {g_row[i-1].cout_row, g_row[i-1].sum[WIDTH-1:1]};
        end

        for (j = 0; j < WIDTH; j++) begin : g_col
            logic ci;
            logic s;
            logic co;

            if (j == 0) begin : g_half
                assign ci = 1'b0;
            end else begin : g_full
                assign ci = g_col[j-1].co;
            end

            full_adder u_fa (
                .a    (pp[i][j]),
                .b    (addend[j]),
                .cin  (ci),
                .sum  (s),
                .cout (co)
            );

            assign sum[j] = s;
        end

        assign cout_row   = g_col[WIDTH-1].co;
        assign product[i] = sum[0];
    end

    assign product[2*WIDTH-1:WIDTH] = {g_row[WIDTH-1].cout_row, g_row[WIDTH-1].sum[WIDTH-1:1]};

    // Y refreshes every cycle; out_valid alone says whether it is meaningful
    always_ff @(posedge clk) begin
        if (rst) begin
            Y         <= '0;
            out_valid <= 1'b0;
        end else begin
            Y         <= product;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_parallel_multiplier.sv
// Scoreboard bench for parallel_multiplier (WIDTH=4): driver pushes expected
// results per cycle, a negedge monitor pops and compares.
module tb_parallel_multiplier;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       in_valid;
    logic [7:0] Y;
    logic       out_valid;

    // {check_y, expected out_valid, expected Y}
    logic [9:0] exp_q[$];
    string      name_q[$];
    int         checks;
    int         failures;

    parallel_multiplier #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .Y         (Y),
        .out_valid (out_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: apply one cycle of inputs and record the response due after the edge
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic v, input logic [7:0] exp_y, input logic chk_y,
                        input string name);
        rst      = r;
        A        = a;
        B        = b;
        in_valid = v;
        @(posedge clk);
        exp_q.push_back({chk_y, (r ? 1'b0 : v), exp_y});
        name_q.push_back(name);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (out_valid !== e[8] || (e[9] && Y !== e[7:0])) begin
                failures++;
                $display("FAIL %s: got out_valid=%0b Y=%0d, expected out_valid=%0b Y=%0d%s",
                         n, out_valid, Y, e[8], e[7:0], e[9] ? "" : " (Y unchecked)");
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        A        = '0;
        B        = '0;
        in_valid = 1'b0;

        // reset holds outputs at zero despite valid operands
        step(1, 4'hF, 4'hF, 1, 8'h00, 1, "reset_0");
        step(1, 4'hF, 4'hF, 1, 8'h00, 1, "reset_1");
        step(0, 4'hF, 4'hF, 1, 8'hE1, 1, "first_after_reset");

        // zero / identity
        step(0, 4'd0,  4'd13, 1, 8'd0,  1, "zero_a");
        step(0, 4'd11, 4'd1,  1, 8'd11, 1, "ident_b");
        step(0, 4'd1,  4'd15, 1, 8'd15, 1, "ident_a");
        step(0, 4'd8,  4'd8,  1, 8'd64, 1, "eight_sq");
        step(0, 4'd13, 4'd0,  1, 8'd0,  1, "zero_b");
        step(0, 4'd3,  4'd5,  1, 8'd15, 1, "three_five");
        step(0, 4'd9,  4'd7,  1, 8'd63, 1, "nine_seven");

        // back-to-back changes
        step(0, 4'd15, 4'd15, 1, 8'd225, 1, "b2b_max");
        step(0, 4'd0,  4'd0,  1, 8'd0,   1, "b2b_zero");
        step(0, 4'd15, 4'd1,  1, 8'd15,  1, "b2b_fifteen");

        // mid-stream reset discards in-flight product
        step(0, 4'd7, 4'd9, 1, 8'd63, 1, "pre_reset");
        step(1, 4'd7, 4'd9, 1, 8'd0,  1, "mid_reset");
        step(0, 4'd1, 4'd1, 1, 8'd1,  1, "post_reset");

        // valid gating
        step(0, 4'd2, 4'd3, 1, 8'd6,  1, "gate_on_0");
        step(0, 4'd5, 4'd5, 0, 8'd0,  0, "gate_off");
        step(0, 4'd4, 4'd4, 1, 8'd16, 1, "gate_on_1");

        // exhaustive sweep, expected product from the bench's own arithmetic
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(0, 4'(a), 4'(b), 1, 8'(a * b), 1, "sweep");
            end
        end

        step(0, 4'd0, 4'd0, 0, 8'd0, 0, "idle");
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
